// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encoding, FSM states and widths shared by the multiply/divide unit
package muldiv_pkg;
  localparam int OP_WIDTH = 3;
  typedef enum logic [OP_WIDTH-1:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative one-bit-per-cycle multiplier and restoring divider
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]    src_a,
  input  logic [WIDTH-1:0]    src_b,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  state_e               state;
  op_e                  op_q;
  logic                 sa_q, sb_q;
  logic [WIDTH-1:0]     opb;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  op_e                  op_i;
  logic                 sa, sb, div_zero, ovf, fast;
  logic [WIDTH-1:0]     a_mag, b_mag, fast_res, q_f, r_f, fin;
  logic [WIDTH:0]       sum, diff;
  logic [2*WIDTH-1:0]   acc_mul, acc_div, p_f;
  assign op_i     = op_e'(op);
  assign sa       = src_a[WIDTH-1] & (op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM);
  assign sb       = src_b[WIDTH-1] & (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
  assign a_mag    = sa ? -src_a : src_a;
  assign b_mag    = sb ? -src_b : src_b;
  assign div_zero = op_i[2] && src_b == '0;
  assign ovf      = (op_i == OP_DIV || op_i == OP_REM) && src_a == {1'b1, {(WIDTH-1){1'b0}}} && src_b == '1;
  assign fast     = div_zero | ovf;
  assign fast_res = div_zero ? (op_i[1] ? src_a : '1) : (op_i[1] ? '0 : src_a);
  // accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign acc_mul  = {sum, acc[WIDTH-1:1]};
  assign diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
  assign acc_div  = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign p_f      = (sa_q ^ sb_q) ? -acc : acc;
  assign q_f      = (sa_q ^ sb_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_f      = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign fin      = op_q[2] ? (op_q[1] ? r_f : q_f) : (op_q == OP_MUL ? p_f[WIDTH-1:0] : p_f[2*WIDTH-1:WIDTH]);
  // the final CALC cycle only applies sign correction, so busy drops there
  assign busy     = state == S_CALC && cnt != LAST;
  assign done     = state == S_DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_MUL;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else if (start && state != S_CALC) begin
      op_q <= op_i;
      sa_q <= sa;
      sb_q <= sb;
      if (fast) begin
        result <= fast_res;
        state  <= S_DONE;
      end else begin
        acc   <= {{WIDTH{1'b0}}, a_mag};
        opb   <= b_mag;
        cnt   <= '0;
        state <= S_CALC;
      end
    end else if (state == S_CALC) begin
      if (cnt == LAST) begin
        result <= fin;
        state  <= S_DONE;
      end else begin
        acc <= op_q[2] ? acc_div : acc_mul;
        cnt <= cnt + 1'b1;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL take parameter WIDTH, default 32, as the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit, as its single clock; all state SHALL update on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, as an asynchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit, which requests a new operation.
REQ-005 The module SHALL have port op, input, 3 bits, selecting MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6 or REMU=7.
REQ-006 The module SHALL have ports src_a and src_b, inputs, WIDTH bits each, as operands (dividend/divisor for divides).
REQ-007 The module SHALL have port flush, input, 1 bit, which aborts the operation in progress.
REQ-008 The module SHALL have port busy, output, 1 bit, asserted while an iterative operation is in progress.
REQ-009 The module SHALL have port done, output, 1 bit, a one-cycle pulse marking result valid.
REQ-010 The module SHALL have port result, output, WIDTH bits, holding the operation result.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE; busy=1 only in CALC, and done=1 only in DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE (back-to-back allowed), with op, src_a and src_b latched on that edge; start during CALC SHALL be ignored.
REQ-013 Normal ops SHALL go IDLE/DONE -> CALC, iterate exactly WIDTH cycles at one bit per cycle (shift-add multiply, restoring divide), then enter DONE.
REQ-014 With start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH+1.
REQ-015 MUL SHALL return the low WIDTH bits of the 2*WIDTH product; MULH, MULHSU and MULHU SHALL return the high WIDTH bits for signed*signed, signed*unsigned and unsigned*unsigned respectively.
REQ-016 Signed ops SHALL iterate on magnitudes and apply the sign correction when entering DONE; quotients SHALL truncate toward zero, and the remainder sign SHALL follow the dividend.
REQ-017 Divide by zero SHALL take a fast path IDLE -> DONE, with done one cycle after the start edge: DIV/DIVU return all ones, REM/REMU return src_a.
REQ-018 Signed overflow (src_a = most-negative, src_b = -1) SHALL take the fast path: DIV returns src_a, REM returns 0.
REQ-019 DONE SHALL last exactly one cycle and return to IDLE unless start is high in that cycle.
REQ-020 result SHALL hold its last value until the next DONE.
REQ-021 flush SHALL force IDLE on the next edge from any state, with no done pulse and result unchanged; flush SHALL have priority over start in the same cycle.

Reset
REQ-022 rst SHALL immediately force state=IDLE, busy=0, done=0, result=0, and clear the iteration counter and internal accumulators.
REQ-023 Reset mid-CALC SHALL discard the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-024 A shared package muldiv_pkg SHALL hold the op encoding enum, the FSM state enum, and the OP_WIDTH=3 constant; the execute stage SHALL import the same package.
REQ-025 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.
REQ-026 The design SHALL be a single module with no sub-module; the shift-add and restoring-divide datapaths SHALL share one 2*WIDTH accumulator register.

Verification (WIDTH=32)
REQ-027 MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, with done exactly 33 cycles after the start edge and busy high for 32 cycles.
REQ-028 MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
REQ-029 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
REQ-030 DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 % 0 -> 5, each with done one cycle after start; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both via the fast path.
REQ-031 start DIV, then flush at cycle 10 -> no done pulse, IDLE next cycle, result unchanged; a start asserted mid-CALC is ignored, and a start in the DONE cycle is accepted.
REQ-032 rst asserted asynchronously mid-CALC -> busy=0, done=0, result=0 immediately; a following MUL 3*4 -> 12.
